// File: rtl/spi_slave_modes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : spi_slave_modes
// SPI slave for all four CPOL/CPHA modes, oversampled on i_clock, with a
// one-entry tx holding buffer and an rx valid/ready handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_slave_modes #(
    parameter int FRAME_SIZE = 32,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  SCLK,
    input  logic                  SC,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_oe,
    input  logic [FRAME_SIZE-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_SIZE-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_active,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_abort
);
    localparam int CW = (FRAME_SIZE > 2) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_SIZE - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state, state_nx;

    logic sclk_s1, sclk_s2, sclk_d, sc_s1, sc_s2, sc_d, mosi_s1, mosi_s2;
    logic [1:0] settle;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic sc_fall, sc_rise, enter, leave;
    logic do_sample, last_sample, do_shift, boundary_load, load, accept;
    logic [FRAME_SIZE-1:0] load_word, tx_buf, tx_shift, rx_shift;
    logic [CW-1:0] bit_cnt;
    logic tx_full, miso_bit, first_pend, bnd_pend, done;

    function automatic logic first_bit(input logic [FRAME_SIZE-1:0] v);
        return (MSB_FIRST != 0) ? v[FRAME_SIZE-1] : v[0];
    endfunction

    function automatic logic [FRAME_SIZE-1:0] advance(input logic [FRAME_SIZE-1:0] v);
        return (MSB_FIRST != 0) ? {v[FRAME_SIZE-2:0], 1'b0} : {1'b0, v[FRAME_SIZE-1:1]};
    endfunction

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sclk_s1 <= (CPOL != 0);
            sclk_s2 <= (CPOL != 0);
            sclk_d  <= (CPOL != 0);
            sc_s1   <= 1'b1;
            sc_s2   <= 1'b1;
            sc_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            settle  <= 2'd0;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            sc_s1   <= SC;
            sc_s2   <= sc_s1;
            sc_d    <= sc_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_d;
    assign sclk_fall   = ~sclk_s2 & sclk_d;
    assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    // An SC held low through reset must not look like a fresh falling edge
    assign sc_fall     = (settle == 2'd3) & sc_d & ~sc_s2;
    assign sc_rise     = ~sc_d & sc_s2;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        enter    = 1'b0;
        leave    = 1'b0;
        case (state)
            IDLE:    if (sc_fall) begin state_nx = ACTIVE; enter = 1'b1; end
            ACTIVE:  if (sc_rise) begin state_nx = IDLE;   leave = 1'b1; end
            default: state_nx = IDLE;
        endcase
    end

    assign frame_active  = (state == ACTIVE);
    assign MISO_oe       = frame_active;
    assign MISO          = frame_active & miso_bit;
    assign tx_ready      = ~tx_full;
    assign do_sample     = frame_active & sample_edge & ~leave;
    assign last_sample   = do_sample & (bit_cnt == LAST_BIT);
    assign do_shift      = frame_active & shift_edge & ~leave;
    // CPHA=0 reloads on the shift edge that follows the last sample so the
    // next frame's first bit appears on a shift edge
    assign boundary_load = (CPHA != 0) ? last_sample : (do_shift & bnd_pend);
    assign load          = enter | boundary_load;
    assign accept        = tx_valid & ~tx_full;
    assign load_word     = tx_full ? tx_buf : '0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            miso_bit    <= 1'b0;
            first_pend  <= 1'b0;
            bnd_pend    <= 1'b0;
            done        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= leave & (bit_cnt != '0);
            done        <= last_sample;

            if (accept) tx_buf <= tx_data;
            tx_full <= (tx_full & ~load) | accept;

            if (load) begin
                tx_shift    <= load_word;
                tx_underrun <= ~tx_full;
                if (CPHA == 0) begin
                    miso_bit   <= first_bit(load_word);
                    first_pend <= 1'b0;
                end else begin
                    first_pend <= 1'b1;
                    if (enter) miso_bit <= 1'b0;
                end
            end else if (do_shift) begin
                if (first_pend) begin
                    miso_bit   <= first_bit(tx_shift);
                    first_pend <= 1'b0;
                end else begin
                    tx_shift <= advance(tx_shift);
                    miso_bit <= first_bit(advance(tx_shift));
                end
            end

            if (load || leave)    bnd_pend <= 1'b0;
            else if (last_sample) bnd_pend <= (CPHA == 0);

            if (enter || leave) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
                rx_shift <= (MSB_FIRST != 0) ? {rx_shift[FRAME_SIZE-2:0], mosi_s2}
                                             : {mosi_s2, rx_shift[FRAME_SIZE-1:1]};
            end

            if (done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_modes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_spi_slave_modes
// Directed bench: modes 0-3 MSB-first plus mode 0 LSB-first, driven in parallel.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_slave_modes;
    localparam int N  = 5;
    localparam int H  = 8;
    localparam int NV = 5;

    logic clk = 1'b0;
    logic rst, sck, sc, mosi_a, mosi_b, tx_valid, rx_ready;
    logic [7:0] tx_data;
    int   last_edge;

    wire [N-1:0]      miso_w, oe_w, tx_ready_w, rx_valid_w, act_w, ovr_w, und_w, abt_w;
    wire [N-1:0][7:0] rx_data_w;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            localparam int P_CPOL = (g == 2 || g == 3) ? 1 : 0;
            localparam int P_CPHA = (g == 1 || g == 3) ? 1 : 0;
            localparam int P_MSB  = (g == 4) ? 0 : 1;
            wire sclk_pin = (P_CPOL != 0) ? ~sck : sck;
            wire mosi_pin = (P_CPHA != 0) ? mosi_b : mosi_a;
            spi_slave_modes #(
                .FRAME_SIZE(8), .CPOL(P_CPOL), .CPHA(P_CPHA), .MSB_FIRST(P_MSB)
            ) dut (
                .i_clock(clk), .i_reset(rst), .SCLK(sclk_pin), .SC(sc), .MOSI(mosi_pin),
                .MISO(miso_w[g]), .MISO_oe(oe_w[g]),
                .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_w[g]),
                .rx_data(rx_data_w[g]), .rx_valid(rx_valid_w[g]), .rx_ready(rx_ready),
                .frame_active(act_w[g]), .rx_overrun(ovr_w[g]),
                .tx_underrun(und_w[g]), .frame_abort(abt_w[g])
            );
        end
    endgenerate

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso_lsb;
        logic [7:0] exp_rx_lsb;
    } vec_t;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    logic [7:0] cap [N];
    logic [7:0] cap1 [N];
    int base [N];

    function automatic bit cpha_of(input int m);
        return (m == 1 || m == 3);
    endfunction

    int ovr_cnt [N] = '{default: 0};
    int und_cnt [N] = '{default: 0};
    int abt_cnt [N] = '{default: 0};
    int edge_viol [N] = '{default: 0};
    int idle_viol [N] = '{default: 0};
    logic [N-1:0] prev_miso = '0;
    logic [N-1:0] prev_oe = '0;

    // Pulse-width counts and MISO-change legality, sampled mid-cycle
    always @(negedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (ovr_w[m]) ovr_cnt[m] <= ovr_cnt[m] + 1;
            if (und_w[m]) und_cnt[m] <= und_cnt[m] + 1;
            if (abt_w[m]) abt_cnt[m] <= abt_cnt[m] + 1;
            if (oe_w[m] && prev_oe[m] && (miso_w[m] != prev_miso[m]) &&
                (last_edge != (cpha_of(m) ? 1 : 0)))
                edge_viol[m] <= edge_viol[m] + 1;
            if (!oe_w[m] && miso_w[m]) idle_viol[m] <= idle_viol[m] + 1;
        end
        prev_miso <= miso_w;
        prev_oe   <= oe_w;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic sc_low();
        sc = 1'b0;
        last_edge = 2;
        cyc(H);
    endtask

    task automatic take_rx();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        cyc(1);
        for (int m = 0; m < N; m++) chk($sformatf("rx_valid_clr[%0d]", m), rx_valid_w[m], 1'b0);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input bit tchk);
        for (int m = 0; m < N; m++) cap[m] = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_a = mo[7-i];
            cyc(H);
            for (int m = 0; m < N; m++) if (!cpha_of(m)) cap[m] = {cap[m][6:0], miso_w[m]};
            sck = 1'b1;
            last_edge = 1;
            mosi_b = mo[7-i];
            if (tchk && i == nbits - 1) begin
                cyc(3);
                for (int m = 0; m < N; m++)
                    if (!cpha_of(m)) chk($sformatf("rx_valid_early[%0d]", m), rx_valid_w[m], 1'b0);
                cyc(1);
                for (int m = 0; m < N; m++)
                    if (!cpha_of(m)) chk($sformatf("rx_valid_lat4[%0d]", m), rx_valid_w[m], 1'b1);
                cyc(H - 4);
            end else begin
                cyc(H);
            end
            for (int m = 0; m < N; m++) if (cpha_of(m)) cap[m] = {cap[m][6:0], miso_w[m]};
            sck = 1'b0;
            last_edge = 0;
            if (tchk && i == nbits - 1) begin
                cyc(3);
                for (int m = 0; m < N; m++)
                    if (cpha_of(m)) chk($sformatf("rx_valid_early[%0d]", m), rx_valid_w[m], 1'b0);
                cyc(1);
                for (int m = 0; m < N; m++)
                    if (cpha_of(m)) chk($sformatf("rx_valid_lat4[%0d]", m), rx_valid_w[m], 1'b1);
            end
        end
        cyc(H);
    endtask

    task automatic run_vec(input int idx, input bit tchk);
        vec_t v;
        v = vecs[idx];
        for (int m = 0; m < N; m++) chk($sformatf("v%0d_tx_ready[%0d]", idx, m), tx_ready_w[m], 1'b1);
        push(v.tx);
        sc_low();
        xfer(v.mosi, 8, tchk);
        sc = 1'b1;
        cyc(H);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("v%0d_rx_valid[%0d]", idx, m), rx_valid_w[m], 1'b1);
            chk($sformatf("v%0d_rx_data[%0d]", idx, m), rx_data_w[m], (m == 4) ? v.exp_rx_lsb : v.exp_rx);
            chk($sformatf("v%0d_miso[%0d]", idx, m), cap[m], (m == 4) ? v.exp_miso_lsb : v.exp_miso);
        end
        take_rx();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("%s_miso[%0d]", tag, m), miso_w[m], 1'b0);
            chk($sformatf("%s_oe[%0d]", tag, m), oe_w[m], 1'b0);
            chk($sformatf("%s_active[%0d]", tag, m), act_w[m], 1'b0);
            chk($sformatf("%s_tx_ready[%0d]", tag, m), tx_ready_w[m], 1'b1);
            chk($sformatf("%s_rx_valid[%0d]", tag, m), rx_valid_w[m], 1'b0);
            chk($sformatf("%s_rx_data[%0d]", tag, m), rx_data_w[m], 8'h00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sck = 1'b0; sc = 1'b1; mosi_a = 1'b0; mosi_b = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; last_edge = 2;
        //          tx     mosi   miso   rx     miso_l rx_l
        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h12, 8'hF0, 8'h12, 8'hF0, 8'h48, 8'h0F};
        vecs[2] = '{8'h01, 8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{8'h6B, 8'h9E, 8'h6B, 8'h9E, 8'hD6, 8'h79};

        cyc(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc(6);

        for (int i = 0; i < NV; i++) run_vec(i, i == 0);

        // Back-to-back frames without rx_ready; second word pushed mid-frame
        for (int m = 0; m < N; m++) base[m] = ovr_cnt[m];
        push(8'h4D);
        sc_low();
        chk("b2b_tx_ready_after_load", tx_ready_w[0], 1'b1);
        push(8'h33);
        chk("b2b_tx_ready_full", tx_ready_w[0], 1'b0);
        xfer(8'hC1, 8, 1'b0);
        cap1 = cap;
        xfer(8'h77, 8, 1'b0);
        sc = 1'b1;
        cyc(H);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("b2b_miso1[%0d]", m), cap1[m], (m == 4) ? 8'hB2 : 8'h4D);
            chk($sformatf("b2b_miso2[%0d]", m), cap[m], (m == 4) ? 8'hCC : 8'h33);
            chk($sformatf("b2b_rx_data[%0d]", m), rx_data_w[m], (m == 4) ? 8'h83 : 8'hC1);
            chk($sformatf("b2b_rx_valid[%0d]", m), rx_valid_w[m], 1'b1);
            chk($sformatf("b2b_overrun[%0d]", m), ovr_cnt[m] - base[m], 1);
        end
        take_rx();

        // Empty tx buffer at SC fall
        for (int m = 0; m < N; m++) base[m] = und_cnt[m];
        sc_low();
        for (int m = 0; m < N; m++) chk($sformatf("underrun[%0d]", m), und_cnt[m] - base[m], 1);
        xfer(8'h96, 8, 1'b0);
        sc = 1'b1;
        cyc(H);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("underrun_miso[%0d]", m), cap[m], 8'h00);
            chk($sformatf("underrun_rx[%0d]", m), rx_data_w[m], (m == 4) ? 8'h69 : 8'h96);
        end
        take_rx();

        // Abort after 5 of 8 bits
        for (int m = 0; m < N; m++) base[m] = abt_cnt[m];
        sc_low();
        xfer(8'hFF, 5, 1'b0);
        sc = 1'b1;
        cyc(H);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("abort_pulse[%0d]", m), abt_cnt[m] - base[m], 1);
            chk($sformatf("abort_rx_valid[%0d]", m), rx_valid_w[m], 1'b0);
            chk($sformatf("abort_rx_data[%0d]", m), rx_data_w[m], (m == 4) ? 8'h69 : 8'h96);
        end
        run_vec(1, 1'b0);

        // Reset at bit 3 with the tx buffer full
        for (int m = 0; m < N; m++) base[m] = abt_cnt[m];
        sc_low();
        xfer(8'hFF, 3, 1'b0);
        push(8'hE7);
        chk("pre_reset_tx_ready", tx_ready_w[0], 1'b0);
        chk("pre_reset_active", act_w[0], 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        cyc(2);
        rst = 1'b0;
        cyc(6);
        sck = 1'b1; last_edge = 1; cyc(H);
        sck = 1'b0; last_edge = 0; cyc(H);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("no_reentry[%0d]", m), act_w[m], 1'b0);
            chk($sformatf("reset_no_abort[%0d]", m), abt_cnt[m] - base[m], 0);
        end
        sc = 1'b1;
        cyc(H);
        run_vec(2, 1'b0);

        cyc(2);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("shift_edge_only[%0d]", m), edge_viol[m], 0);
            chk($sformatf("miso_zero_when_off[%0d]", m), idle_viol[m], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_modes.md
SPI_SLAVE_MODES -- requirements
Module: spi_slave_modes

Interface
REQ-001 The block SHALL have parameter FRAME_SIZE, default 32, bits per frame (legal 2..64).
REQ-002 The block SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-003 The block SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit FRAME_SIZE-1 first, 0 = bit 0 first.
REQ-005 Port i_clock: input, 1 bit, system clock; all logic runs on its rising edge.
REQ-006 Port i_reset: input, 1 bit, asynchronous active-high reset.
REQ-007 Port SCLK: input, 1 bit, SPI clock from master, asynchronous to i_clock.
REQ-008 Port SC: input, 1 bit, slave select, active low.
REQ-009 Port MOSI: input, 1 bit, serial data from master.
REQ-010 Port MISO: output, 1 bit, serial data to master.
REQ-011 Port MISO_oe: output, 1 bit, MISO drive enable; high only while the frame state is ACTIVE.
REQ-012 Port tx_data: input, FRAME_SIZE bits, next frame to send.
REQ-013 Port tx_valid / tx_ready: input / output, 1 bit each, tx handshake.
REQ-014 Port rx_data: output, FRAME_SIZE bits, last complete received frame.
REQ-015 Port rx_valid / rx_ready: output / input, 1 bit each, rx handshake.
REQ-016 Port frame_active: output, 1 bit, high in ACTIVE state.
REQ-017 Ports rx_overrun, tx_underrun, frame_abort: outputs, 1 bit each, one-cycle event pulses.

Function
REQ-018 SCLK, SC and MOSI SHALL each pass through a 2-flop synchroniser, plus one history flop for edge detection.
REQ-019 Required SCLK rate SHALL be at most i_clock/4; higher rates are unsupported.
REQ-020 Leading edge = SCLK rising when CPOL=0, falling when CPOL=1; trailing edge is the opposite.
REQ-021 Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1; shift edge is the other edge.
REQ-022 The FSM SHALL have states IDLE and ACTIVE: IDLE->ACTIVE on synchronised SC falling; ACTIVE->IDLE on synchronised SC rising.
REQ-023 On entry to ACTIVE and at each frame boundary, the block SHALL load the tx holding buffer into the shift register and clear the bit counter.
REQ-024 If the holding buffer is empty at load time, the block SHALL shift all-zeros and pulse tx_underrun for one cycle.
REQ-025 The tx holding buffer SHALL be one entry; tx_ready = buffer empty; a transfer occurs when tx_valid and tx_ready are both high.
REQ-026 A load and an accept in the same cycle SHALL both take effect, leaving the new word in the buffer.
REQ-027 With CPHA=0, MISO SHALL present the first bit in the cycle ACTIVE is entered; each shift edge advances one bit.
REQ-028 With CPHA=1, MISO SHALL present the first bit on the first leading edge; each later shift edge advances one bit.
REQ-029 Bit order on MISO and on MOSI assembly SHALL follow MSB_FIRST.
REQ-030 Each sample edge SHALL capture synchronised MOSI and increment the bit counter.
REQ-031 On the FRAME_SIZE-th sample edge, the counter SHALL wrap to 0 and the assembled frame SHALL go to rx_data.
REQ-032 The frame-completion update of rx_data SHALL set rx_valid in the cycle after that edge is detected, i.e. 4 i_clock cycles after the pin edge.
REQ-033 rx_valid SHALL stay high until a cycle with rx_ready high, then clear on the next cycle.
REQ-034 If a frame completes while rx_valid is high and rx_ready is low, rx_data SHALL be retained, the new frame discarded, and rx_overrun pulsed for one cycle.
REQ-035 If a frame completes in a cycle where rx_ready is high, the new frame SHALL be delivered and no overrun raised.
REQ-036 Back-to-back frames with SC held low SHALL be supported with no gap.
REQ-037 SC rising with the bit counter nonzero SHALL discard the partial frame, pulse frame_abort, and leave the tx buffer and rx_data unchanged.
REQ-038 MISO SHALL be 0 whenever MISO_oe is low.

Reset
REQ-039 While i_reset is high, the block SHALL force: state IDLE; counters 0; shift registers 0; MISO=0; MISO_oe=0; tx_ready=1 (buffer empty); rx_data=0; rx_valid=0; frame_active=0; all pulses 0; synchronisers to SC=1 and SCLK=CPOL.
REQ-040 Reset asserted mid-frame SHALL abort the frame without a frame_abort pulse.
REQ-041 After reset release, the block SHALL wait for a fresh SC falling edge before entering ACTIVE.

Verification
REQ-042 Mode 0, FRAME_SIZE=8, MSB first: tx 0xA5 loaded; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid 4 cycles after the 8th rising edge.
REQ-043 Each of modes 1, 2 and 3 with 0xA5/0x3C -> same data result; MISO changes only on that mode's shift edge.
REQ-044 Two back-to-back frames without rx_ready: rx_data=first frame, rx_overrun=1 for one cycle; rx_ready then clears rx_valid.
REQ-045 No tx_valid before SC falls -> MISO all zeros, tx_underrun pulse; tx_valid mid-frame -> word sent in the next frame.
REQ-046 SC raised after 5 of 8 bits -> frame_abort pulse, rx_valid stays 0; next full frame received correctly.
REQ-047 i_reset pulsed at bit 3 -> all outputs at reset values within the same cycle; next frame correct after fresh SC falling edge.
